// File: rtl/mem_region_ctrl_if.sv
// mem_region_ctrl_if: CPU/DMA request/done bus of the region controller.
// MEM_BUS_ERR_EN adds the bus_err completion flag.
interface mem_region_ctrl_if;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [1:0]  bus_size;
  logic        bus_write;
  logic [31:0] bus_rdata;
  logic        bus_pause;
  logic        bus_done;
`ifdef MEM_BUS_ERR_EN
  logic        bus_err;
`endif

  modport master (
    output bus_valid, bus_addr, bus_wdata,
    output bus_size, bus_write,
    input  bus_rdata, bus_pause, bus_done
`ifdef MEM_BUS_ERR_EN
    , input bus_err
`endif
  );

  modport slave (
    input  bus_valid, bus_addr, bus_wdata,
    input  bus_size, bus_write,
    output bus_rdata, bus_pause, bus_done
`ifdef MEM_BUS_ERR_EN
    , output bus_err
`endif
  );
endinterface

// File: rtl/mem_region_ctrl.sv
// mem_region_ctrl: CPU/DMA + graphics front end for dual-port BRAM regions.
// MEM_BUS_ERR_EN: exposes bus_err on error completions (silent otherwise).
module mem_region_ctrl #(
  parameter int NUM_REGIONS = 5,
  parameter logic [32*NUM_REGIONS-1:0] REGION_BASE = {
    32'h0700_0000, 32'h0600_0000, 32'h0500_0000,
    32'h0300_0000, 32'h0000_0000},
  parameter logic [32*NUM_REGIONS-1:0] REGION_SIZE = {
    32'h0000_0400, 32'h0001_8000, 32'h0000_0400,
    32'h0000_8000, 32'h0000_4000},
  parameter logic [4*NUM_REGIONS-1:0] REGION_WS = {
    4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
  parameter logic [NUM_REGIONS-1:0] REGION_RO = 5'b00001
) (
  input  logic                        clock,
  input  logic                        reset_n,
  mem_region_ctrl_if.slave            bus,
  output logic [NUM_REGIONS-1:0]      mem_en,
  output logic [3:0]                  mem_we,
  output logic [31:0]                 mem_addr,
  output logic [31:0]                 mem_wdata,
  input  logic [32*NUM_REGIONS-1:0]   mem_rdata,
  input  logic [31:0]                 gfx_addr,
  output logic [NUM_REGIONS-1:0]      gfx_en,
  output logic [31:0]                 gfx_mem_addr,
  input  logic [32*NUM_REGIONS-1:0]   gfx_rdata,
  output logic [31:0]                 gfx_data
);
  localparam int IW =
    (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  typedef logic [IW-1:0] idx_t;
  typedef logic [NUM_REGIONS-1:0] oh_t;

  typedef struct packed {
    logic hit;
    idx_t idx;
  } dec_t;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ISSUE, S_READ, S_DONE
  } state_t;

  function automatic logic [31:0] base_of(input idx_t i);
    return REGION_BASE[32*i +: 32];
  endfunction

  // Scan high to low so the lowest matching region wins.
  function automatic dec_t decode(input logic [31:0] a);
    dec_t d;
    d = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (a - REGION_BASE[32*i +: 32] <
          REGION_SIZE[32*i +: 32]) begin
        d.hit = 1'b1;
        d.idx = idx_t'(i);
      end
    end
    return d;
  endfunction

  function automatic oh_t onehot(input idx_t i);
    oh_t o;
    o = '0;
    o[i] = 1'b1;
    return o;
  endfunction

  function automatic logic [3:0] be_of(
    input logic [1:0] a,
    input logic [1:0] size
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (1'b1)
      size == 2'd0: be = 4'b0001 << a;
      size == 2'd1: be = a[1] ? 4'b1100 : 4'b0011;
      size == 2'd2: be = 4'b1111;
      default:      be = 4'b0000;
    endcase
    return be;
  endfunction

  state_t      state;
  logic [3:0]  cnt;
  idx_t        idx_q;
  logic        wr_q;
  logic        ro_q;
  logic [3:0]  we_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        err_q;
  logic        g_hit;
  idx_t        g_idx;

  dec_t        bd;
  dec_t        gd;
  logic        acc_err;
  logic        acc_ro;
  logic [3:0]  acc_we;
  logic [3:0]  acc_ws;

  assign bd      = decode(bus.bus_addr);
  assign acc_err = !bd.hit || (bus.bus_size == 2'd3);
  assign acc_ro  = bus.bus_write && REGION_RO[bd.idx];
  assign acc_ws  = REGION_WS[4*bd.idx +: 4];
  assign acc_we  = (bus.bus_write && !acc_ro)
                 ? be_of(bus.bus_addr[1:0], bus.bus_size)
                 : 4'b0000;

  // Bus request sequencer: accept, wait states, one-cycle issue, done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      ro_q      <= 1'b0;
      we_q      <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mem_en    <= '0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= '0;
      mem_we <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.bus_valid) begin
            idx_q     <= bd.idx;
            wr_q      <= bus.bus_write;
            ro_q      <= acc_ro;
            we_q      <= acc_we;
            mem_addr  <= bus.bus_addr - base_of(bd.idx);
            mem_wdata <= bus.bus_wdata;
            rdata_q   <= '0;
            if (acc_err) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (acc_ws != 4'd0) begin
              state <= S_WAIT;
              cnt   <= acc_ws - 4'd1;
            end else begin
              state  <= S_ISSUE;
              mem_en <= onehot(bd.idx);
              mem_we <= acc_we;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state  <= S_ISSUE;
            mem_en <= onehot(idx_q);
            mem_we <= we_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ISSUE: begin
          if (wr_q) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            err_q  <= ro_q;
          end else begin
            state <= S_READ;
          end
        end
        S_READ: begin
          rdata_q <= mem_rdata[32*idx_q +: 32];
          state   <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.bus_pause = (state == S_IDLE)
                       ? bus.bus_valid
                       : (state != S_DONE);
  assign bus.bus_rdata = rdata_q;
  assign bus.bus_done  = done_q;

`ifdef MEM_BUS_ERR_EN
  assign bus.bus_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

  assign gd           = decode(gfx_addr);
  assign gfx_en       = gd.hit ? onehot(gd.idx) : '0;
  assign gfx_mem_addr = gd.hit
                      ? gfx_addr - base_of(gd.idx)
                      : '0;

  // Graphics hit index follows the BRAM's one-cycle read latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      g_hit <= 1'b0;
      g_idx <= '0;
    end else begin
      g_hit <= gd.hit;
      g_idx <= gd.idx;
    end
  end

  assign gfx_data = g_hit ? gfx_rdata[32*g_idx +: 32] : '0;
endmodule

// File: tb/tb_mem_region_ctrl.sv
// tb_mem_region_ctrl: directed bench with a cycle-level reference model.
// VRAM (region 3) runs with 3 wait states here.
module tb_mem_region_ctrl;
  localparam int NR = 5;
  localparam logic [31:0] TB_BASE [NR] = '{
    32'h0000_0000, 32'h0300_0000, 32'h0500_0000,
    32'h0600_0000, 32'h0700_0000};
  localparam logic [31:0] TB_SIZE [NR] = '{
    32'h0000_4000, 32'h0000_8000, 32'h0000_0400,
    32'h0001_8000, 32'h0000_0400};
  localparam int TB_WS [NR] = '{0, 0, 0, 3, 0};
  localparam logic [NR-1:0] TB_RO = 5'b00001;

  typedef struct packed {
    logic        pause;
    logic        done;
    logic        err;
    logic        rd_chk;
    logic [4:0]  en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  mem_region_ctrl_if bus ();

  logic [NR-1:0]    mem_en;
  logic [3:0]       mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [32*NR-1:0] mem_rdata;
  logic [31:0]      gfx_addr;
  logic [NR-1:0]    gfx_en;
  logic [31:0]      gfx_mem_addr;
  logic [32*NR-1:0] gfx_rdata;
  logic [31:0]      gfx_data;

  mem_region_ctrl #(
    .REGION_WS(20'h03000)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .gfx_addr(gfx_addr),
    .gfx_en(gfx_en),
    .gfx_mem_addr(gfx_mem_addr),
    .gfx_rdata(gfx_rdata),
    .gfx_data(gfx_data)
  );

  function automatic logic [31:0] pat(input int r, input int w);
    return {8'(r), 8'h5A, 16'(w)};
  endfunction

  // Dual-port BRAM stand-in: synchronous read, read-before-write.
  logic [31:0] ram [NR][256];
  logic [31:0] mem_dout [NR];
  logic [31:0] gfx_dout [NR];
  bit ram_init;

  always @(posedge clock) begin
    if (!ram_init) begin
      for (int i = 0; i < NR; i++)
        for (int w = 0; w < 256; w++)
          ram[i][w] <= pat(i, w);
      ram_init <= 1'b1;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (mem_en[i]) begin
          for (int b = 0; b < 4; b++)
            if (mem_we[b])
              ram[i][mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
          mem_dout[i] <= ram[i][mem_addr[9:2]];
        end
        if (gfx_en[i])
          gfx_dout[i] <= ram[i][gfx_mem_addr[9:2]];
      end
    end
  end

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign mem_rdata[32*g +: 32] = mem_dout[g];
    assign gfx_rdata[32*g +: 32] = gfx_dout[g];
  end

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  exp_t exp_q [int];
  logic [31:0] shadow [NR][256];
  logic [31:0] gfx_exp = '0;

  int          en_count, we_count, en_cyc;
  logic [4:0]  en_val;
  logic [3:0]  we_val;
  logic [31:0] addr_val, rdata_val;
  logic        err_val;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] gfx_model(input logic [31:0] a);
    int r;
    logic [31:0] off;
    r = -1;
    for (int i = NR - 1; i >= 0; i--)
      if (a - TB_BASE[i] < TB_SIZE[i]) r = i;
    if (r < 0) return '0;
    off = a - TB_BASE[r];
    return shadow[r][off[9:2]];
  endfunction

  // Per-cycle comparison against the model timeline.
  always @(negedge clock) begin
    exp_t e;
    e = exp_q.exists(cyc) ? exp_q[cyc] : '0;
    if (!reset_n) gfx_exp = '0;
    check("gfx_data", gfx_data, gfx_exp);
    if (chk_on) begin
      check("bus_pause", 32'(bus.bus_pause), 32'(e.pause));
      check("bus_done", 32'(bus.bus_done), 32'(e.done));
      check("mem_en", 32'(mem_en), 32'(e.en));
      check("mem_we", 32'(mem_we), 32'(e.we));
      if (e.en != '0) check("mem_addr", mem_addr, e.addr);
      if (e.we != '0) check("mem_wdata", mem_wdata, e.wdata);
      if (e.done && e.rd_chk)
        check("bus_rdata", bus.bus_rdata, e.rdata);
`ifdef MEM_BUS_ERR_EN
      check("bus_err", 32'(bus.bus_err), 32'(e.err));
`endif
    end
    gfx_exp = reset_n ? gfx_model(gfx_addr) : '0;
    if (mem_en != '0) begin
      en_count++;
      en_cyc   = cyc;
      en_val   = mem_en;
      we_val   = mem_we;
      addr_val = mem_addr;
    end
    if (mem_we != '0) we_count++;
    if (bus.bus_done) begin
      rdata_val = bus.bus_rdata;
`ifdef MEM_BUS_ERR_EN
      err_val = bus.bus_err;
`else
      err_val = 1'b0;
`endif
    end
  end

  // Call just after a posedge with the bus idle.
  task automatic txn(input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input logic w,
                     output int lat, output int c0);
    int r, ws, len, n;
    bit err, ro;
    logic [31:0] off;
    logic [3:0] be;
    exp_t e;
    c0 = cyc;
    en_count = 0;
    we_count = 0;
    en_cyc = -1;
    rdata_val = 32'hFFFF_FFFF;
    err_val = 1'b0;
    bus.bus_valid = 1'b1;
    bus.bus_addr  = a;
    bus.bus_wdata = wd;
    bus.bus_size  = sz;
    bus.bus_write = w;
    r = -1;
    for (int i = NR - 1; i >= 0; i--)
      if (a - TB_BASE[i] < TB_SIZE[i]) r = i;
    err = (r < 0) || (sz == 2'd3);
    if (err) begin
      e = '0;
      e.pause = 1'b1;
      exp_q[c0] = e;
      e = '0;
      e.done = 1'b1;
      e.err = 1'b1;
      e.rd_chk = 1'b1;
      exp_q[c0 + 1] = e;
    end else begin
      off = a - TB_BASE[r];
      ws = TB_WS[r];
      ro = w && TB_RO[r];
      case (sz)
        2'd0:    be = 4'b0001 << a[1:0];
        2'd1:    be = a[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
      len = ws + (w ? 2 : 3);
      for (int k = 0; k <= len; k++) begin
        e = '0;
        e.pause = (k < len);
        if (k == ws + 1) begin
          e.en = 5'(1 << r);
          e.we = (w && !ro) ? be : 4'b0000;
          e.addr = off;
          e.wdata = wd;
        end
        if (k == len) begin
          e.done = 1'b1;
          e.err = ro;
          e.rd_chk = !w || ro;
          e.rdata = w ? 32'h0 : shadow[r][off[9:2]];
        end
        exp_q[c0 + k] = e;
      end
      if (w && !ro)
        for (int b = 0; b < 4; b++)
          if (be[b])
            shadow[r][off[9:2]][8*b +: 8] = wd[8*b +: 8];
    end
    n = 0;
    lat = -1;
    while (n < 40) begin
      @(negedge clock);
      if (bus.bus_done) begin
        lat = cyc - c0;
        break;
      end
      n++;
    end
    if (lat < 0) begin
      n_checks++;
      n_err++;
      $display("FAIL txn_timeout: addr %h no bus_done in 40 cycles", a);
    end
    @(posedge clock);
    #1;
    bus.bus_valid = 1'b0;
  endtask

  int lat, c0;
  logic [31:0] gsweep [6] = '{
    32'h0000_0000, 32'h0300_0004, 32'h0500_0000,
    32'h0600_0010, 32'h0400_0000, 32'h0700_0400};

  initial begin
    reset_n = 1'b0;
    bus.bus_valid = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_wdata = '0;
    bus.bus_size  = '0;
    bus.bus_write = 1'b0;
    gfx_addr = 32'h0400_0000;
    for (int i = 0; i < NR; i++)
      for (int w = 0; w < 256; w++)
        shadow[i][w] = pat(i, w);
    repeat (3) @(posedge clock);
    #1;
    check("rst_pause", 32'(bus.bus_pause), 0);
    check("rst_done", 32'(bus.bus_done), 0);
    check("rst_en", 32'(mem_en), 0);
    check("rst_rdata", bus.bus_rdata, 0);
    check("rst_gfx", gfx_data, 0);
    reset_n = 1'b1;
    chk_on = 1'b1;
    @(posedge clock);
    #1;

    foreach (gsweep[k]) begin
      gfx_addr = gsweep[k];
      @(posedge clock);
      #1;
    end
    gfx_addr = 32'h0700_03FC;
    @(posedge clock);
    #1;
    check("gfx_oam_end", gfx_data, 32'h045A_00FF);
    gfx_addr = 32'h0400_0000;

    txn(32'h0300_0010, 32'hDEAD_BEEF, 2'd2, 1'b1, lat, c0);
    check("wr_lat", lat, 2);
    check("wr_en", 32'(en_val), 32'h02);
    check("wr_we", 32'(we_val), 32'hF);
    check("wr_addr", addr_val, 32'h10);

    txn(32'h0300_0010, 32'h0, 2'd2, 1'b0, lat, c0);
    check("rd_lat", lat, 3);
    check("rd_data", rdata_val, 32'hDEAD_BEEF);

    txn(32'h0500_0002, 32'h1234_0000, 2'd1, 1'b1, lat, c0);
    check("half_we", 32'(we_val), 32'hC);
    check("half_addr", addr_val, 32'h2);

    txn(32'h0600_0003, 32'hAB00_0000, 2'd0, 1'b1, lat, c0);
    check("byte_we", 32'(we_val), 32'h8);
    check("byte_addr", addr_val, 32'h3);
    check("byte_lat", lat, 5);

    txn(32'h0600_0000, 32'h0, 2'd2, 1'b0, lat, c0);
    check("vram_lat", lat, 6);
    check("vram_en_cyc", en_cyc - c0, 4);
    check("vram_en_cnt", en_count, 1);
    check("vram_data", rdata_val, 32'hAB5A_0000);

    txn(32'h0000_0100, 32'hFFFF_FFFF, 2'd2, 1'b1, lat, c0);
    check("ro_lat", lat, 2);
    check("ro_we_cnt", we_count, 0);
    check("ro_en_cnt", en_count, 1);
    check("ro_rdata", rdata_val, 0);
    check("ro_ram", ram[0][64], 32'h005A_0040);
`ifdef MEM_BUS_ERR_EN
    check("ro_err", 32'(err_val), 1);
`endif

    txn(32'h0400_0000, 32'h0, 2'd2, 1'b0, lat, c0);
    check("unmap_lat", lat, 1);
    check("unmap_rdata", rdata_val, 0);
    check("unmap_en_cnt", en_count, 0);
`ifdef MEM_BUS_ERR_EN
    check("unmap_err", 32'(err_val), 1);
`endif

    txn(32'h0300_0000, 32'h0, 2'd3, 1'b0, lat, c0);
    check("size3_lat", lat, 1);

    txn(32'h0000_4000, 32'h0, 2'd0, 1'b0, lat, c0);
    check("bios_past_lat", lat, 1);
    txn(32'h0000_3FFF, 32'h0, 2'd0, 1'b0, lat, c0);
    check("bios_last_lat", lat, 3);

    txn(32'h0300_0021, 32'h0000_7700, 2'd0, 1'b1, lat, c0);
    check("lane1_we", 32'(we_val), 32'h2);
    txn(32'h0300_0020, 32'h0, 2'd2, 1'b0, lat, c0);
    check("lane1_merge", rdata_val, 32'h015A_7708);

    gfx_addr = 32'h0700_0008;
    txn(32'h0700_0008, 32'h0, 2'd2, 1'b0, lat, c0);
    check("oam_bus", rdata_val, 32'h045A_0002);
    check("oam_gfx", gfx_data, 32'h045A_0002);

    chk_on = 1'b0;
    we_count = 0;
    bus.bus_valid = 1'b1;
    bus.bus_addr  = 32'h0600_0040;
    bus.bus_wdata = 32'h1111_1111;
    bus.bus_size  = 2'd2;
    bus.bus_write = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("wait_pause", 32'(bus.bus_pause), 1);
    reset_n = 1'b0;
    bus.bus_valid = 1'b0;
    #1;
    check("arst_pause", 32'(bus.bus_pause), 0);
    check("arst_done", 32'(bus.bus_done), 0);
    check("arst_en", 32'(mem_en), 0);
    check("arst_we", 32'(mem_we), 0);
    check("arst_rdata", bus.bus_rdata, 0);
    check("arst_gfx", gfx_data, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("post_rst_gfx", gfx_data, 32'h045A_0002);
    repeat (6) @(posedge clock);
    #1;
    check("rst_no_write", we_count, 0);
    check("rst_ram", ram[3][16], 32'h035A_0010);
    chk_on = 1'b1;

    txn(32'h0600_0040, 32'h0, 2'd2, 1'b0, lat, c0);
    check("recover_lat", lat, 6);
    check("recover_data", rdata_val, 32'h035A_0010);

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end
endmodule
